// File: rtl/router_fsm_nch.sv
// Control FSM for a 1-to-NUM_CH packet router.
// Decodes the header address, steers FIFO writes through a one-hot select and
// sequences first-data, payload, parity, full-stall and parity-check phases.
// Headers addressing a channel that does not exist, and packets that wait too
// long for their FIFO to drain, are consumed in DROP_PKT without any write.
module router_fsm_nch #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned WAIT_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_pkt_valid,
  input  logic              i_low_pkt_valid,
  input  logic              i_parity_done,
  input  logic [ADDR_W-1:0] i_din,
  input  logic [NUM_CH-1:0] i_fifo_empty,
  input  logic [NUM_CH-1:0] i_fifo_full,
  input  logic [NUM_CH-1:0] i_soft_rst,
  output logic              o_busy,
  output logic              o_detect_add,
  output logic              o_lfd_state,
  output logic              o_ld_state,
  output logic              o_laf_state,
  output logic              o_full_state,
  output logic              o_rst_int_reg,
  output logic              o_drop_state,
  output logic              o_we_reg,
  output logic [NUM_CH-1:0] o_wr_sel,
  output logic              o_wait_timeout
);

  // Wide enough to count 0 .. WAIT_TIMEOUT-1; a single bit when the timeout is off.
  localparam int unsigned CntW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StDecodeAddr     = 4'd0,
    StLoadFirstData  = 4'd1,
    StWaitTillEmpty  = 4'd2,
    StLoadData       = 4'd3,
    StLoadParity     = 4'd4,
    StFifoFull       = 4'd5,
    StLoadAfterFull  = 4'd6,
    StCheckParityErr = 4'd7,
    StDropPkt        = 4'd8
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CntW-1:0]   r_wait_cnt;
  logic [CntW-1:0]   w_wait_cnt_nxt;
  logic              r_wait_to;
  logic              w_wait_to_nxt;

  logic              w_full_sel;   // fifo_full of the latched channel
  logic              w_empty_sel;  // fifo_empty of the latched channel
  logic              w_srst_sel;   // soft reset of the latched channel
  logic              w_empty_din;  // fifo_empty of the channel named on din
  logic              w_din_ok;     // din addresses an existing channel
  logic [NUM_CH-1:0] w_sel_oh;     // one-hot of the latched channel
  logic              w_to_hit;     // wait budget exhausted this cycle

  // Per-channel lookups; an out-of-range address selects nothing (all zeros).
  always_comb begin
    w_full_sel  = 1'b0;
    w_empty_sel = 1'b0;
    w_srst_sel  = 1'b0;
    w_empty_din = 1'b0;
    w_sel_oh    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_addr == ADDR_W'(i)) begin
        w_full_sel  = i_fifo_full[i];
        w_empty_sel = i_fifo_empty[i];
        w_srst_sel  = i_soft_rst[i];
        w_sel_oh[i] = 1'b1;
      end
      if (i_din == ADDR_W'(i)) begin
        w_empty_din = i_fifo_empty[i];
      end
    end
  end

  assign w_din_ok = (32'(i_din) < NUM_CH);

  // Next-state logic, with the selected channel's soft reset overriding it.
  always_comb begin
    w_state_nxt = r_state;
    w_to_hit    = 1'b0;
    case (r_state)
      StDecodeAddr: begin
        if (i_pkt_valid) begin
          if (!w_din_ok) begin
            w_state_nxt = StDropPkt;
          end else if (w_empty_din) begin
            w_state_nxt = StLoadFirstData;
          end else begin
            w_state_nxt = StWaitTillEmpty;
          end
        end
      end
      StLoadFirstData: begin
        w_state_nxt = StLoadData;
      end
      StWaitTillEmpty: begin
        // Draining wins over the timeout when both happen in the same cycle.
        if (w_empty_sel) begin
          w_state_nxt = StLoadFirstData;
        end else if ((WAIT_TIMEOUT != 0) && (r_wait_cnt == CntW'(WAIT_TIMEOUT - 1))) begin
          w_state_nxt = StDropPkt;
          w_to_hit    = 1'b1;
        end
      end
      StLoadData: begin
        if (w_full_sel) begin
          w_state_nxt = StFifoFull;
        end else if (!i_pkt_valid) begin
          w_state_nxt = StLoadParity;
        end
      end
      StLoadParity: begin
        w_state_nxt = StCheckParityErr;
      end
      StFifoFull: begin
        if (!w_full_sel) begin
          w_state_nxt = StLoadAfterFull;
        end
      end
      StLoadAfterFull: begin
        if (i_parity_done) begin
          w_state_nxt = StDecodeAddr;
        end else if (i_low_pkt_valid) begin
          w_state_nxt = StLoadParity;
        end else begin
          w_state_nxt = StLoadData;
        end
      end
      StCheckParityErr: begin
        w_state_nxt = w_full_sel ? StFifoFull : StDecodeAddr;
      end
      StDropPkt: begin
        // Trailing parity arrives with pkt_valid low and is simply not consumed.
        if (!i_pkt_valid) begin
          w_state_nxt = StDecodeAddr;
        end
      end
      default: begin
        w_state_nxt = StDecodeAddr;
      end
    endcase

    if ((r_state != StDecodeAddr) && w_srst_sel) begin
      w_state_nxt = StDecodeAddr;
    end
  end

  // Wait counter restarts from zero on every entry to WAIT_TILL_EMPTY.
  always_comb begin
    w_wait_cnt_nxt = '0;
    if (r_state == StWaitTillEmpty) begin
      w_wait_cnt_nxt = r_wait_cnt + CntW'(1);
    end
  end

  // Timeout pulse only when the drop actually happens (a soft reset pre-empts it).
  assign w_wait_to_nxt = w_to_hit && (w_state_nxt == StDropPkt);

  // State, address latch, wait counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= StDecodeAddr;
      r_addr     <= '0;
      r_wait_cnt <= '0;
      r_wait_to  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_wait_to  <= w_wait_to_nxt;
      if ((r_state == StDecodeAddr) && i_pkt_valid) begin
        r_addr <= i_din;
      end
    end
  end

  // Moore output decode; unused encodings leave every output low.
  always_comb begin
    o_busy        = 1'b0;
    o_detect_add  = 1'b0;
    o_lfd_state   = 1'b0;
    o_ld_state    = 1'b0;
    o_laf_state   = 1'b0;
    o_full_state  = 1'b0;
    o_rst_int_reg = 1'b0;
    o_drop_state  = 1'b0;
    o_we_reg      = 1'b0;
    o_wr_sel      = '0;
    case (r_state)
      StDecodeAddr: begin
        o_detect_add = 1'b1;
      end
      StLoadFirstData: begin
        o_busy      = 1'b1;
        o_lfd_state = 1'b1;
        o_wr_sel    = w_sel_oh;
      end
      StWaitTillEmpty: begin
        o_busy = 1'b1;
      end
      StLoadData: begin
        o_ld_state = 1'b1;
        o_we_reg   = 1'b1;
        o_wr_sel   = w_sel_oh;
      end
      StLoadParity: begin
        o_busy   = 1'b1;
        o_we_reg = 1'b1;
        o_wr_sel = w_sel_oh;
      end
      StFifoFull: begin
        o_busy       = 1'b1;
        o_full_state = 1'b1;
      end
      StLoadAfterFull: begin
        o_busy      = 1'b1;
        o_laf_state = 1'b1;
        o_we_reg    = 1'b1;
        o_wr_sel    = w_sel_oh;
      end
      StCheckParityErr: begin
        o_busy        = 1'b1;
        o_rst_int_reg = 1'b1;
      end
      StDropPkt: begin
        o_drop_state = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_wait_timeout = r_wait_to;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch: two instances share stimulus, one with the
// default 32-cycle wait budget and one with an 8-cycle budget for the drop test.
module tb_router_fsm_nch;

  localparam int E_DA   = 0;
  localparam int E_LFD  = 1;
  localparam int E_WAIT = 2;
  localparam int E_LD   = 3;
  localparam int E_LP   = 4;
  localparam int E_FULL = 5;
  localparam int E_LAF  = 6;
  localparam int E_CPE  = 7;
  localparam int E_DROP = 8;

  logic       clk;
  logic       rstn;
  logic       pkt_valid;
  logic       low_pkt_valid;
  logic       parity_done;
  logic [1:0] din;
  logic [2:0] fifo_empty;
  logic [2:0] fifo_full;
  logic [2:0] soft_rst;

  logic       a_busy, a_da, a_lfd, a_ld, a_laf, a_full, a_rst, a_drop, a_we, a_wto;
  logic [2:0] a_sel;
  logic       b_busy, b_da, b_lfd, b_ld, b_laf, b_full, b_rst, b_drop, b_we, b_wto;
  logic [2:0] b_sel;

  int n_checks = 0;
  int n_fail   = 0;

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(32)) dut (
    .clk(clk), .rstn(rstn), .i_pkt_valid(pkt_valid), .i_low_pkt_valid(low_pkt_valid),
    .i_parity_done(parity_done), .i_din(din), .i_fifo_empty(fifo_empty),
    .i_fifo_full(fifo_full), .i_soft_rst(soft_rst), .o_busy(a_busy), .o_detect_add(a_da),
    .o_lfd_state(a_lfd), .o_ld_state(a_ld), .o_laf_state(a_laf), .o_full_state(a_full),
    .o_rst_int_reg(a_rst), .o_drop_state(a_drop), .o_we_reg(a_we), .o_wr_sel(a_sel),
    .o_wait_timeout(a_wto)
  );

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) dut8 (
    .clk(clk), .rstn(rstn), .i_pkt_valid(pkt_valid), .i_low_pkt_valid(low_pkt_valid),
    .i_parity_done(parity_done), .i_din(din), .i_fifo_empty(fifo_empty),
    .i_fifo_full(fifo_full), .i_soft_rst(soft_rst), .o_busy(b_busy), .o_detect_add(b_da),
    .o_lfd_state(b_lfd), .o_ld_state(b_ld), .o_laf_state(b_laf), .o_full_state(b_full),
    .o_rst_int_reg(b_rst), .o_drop_state(b_drop), .o_we_reg(b_we), .o_wr_sel(b_sel),
    .o_wait_timeout(b_wto)
  );

  // Output word: {busy, detect_add, lfd, ld, laf, full, rst_int, drop, we, wr_sel[2:0], wto}
  logic [12:0] obs_a, obs_b;
  assign obs_a = {a_busy, a_da, a_lfd, a_ld, a_laf, a_full, a_rst, a_drop, a_we, a_sel, a_wto};
  assign obs_b = {b_busy, b_da, b_lfd, b_ld, b_laf, b_full, b_rst, b_drop, b_we, b_sel, b_wto};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_word(input int st, input logic [2:0] sel, input logic wto);
    logic [8:0] d;
    logic [2:0] s;
    s = 3'b000;
    case (st)
      E_DA:    d = 9'b0_1000_0000;
      E_LFD:   begin d = 9'b1_0100_0000; s = sel; end
      E_WAIT:  d = 9'b1_0000_0000;
      E_LD:    begin d = 9'b0_0010_0001; s = sel; end
      E_LP:    begin d = 9'b1_0000_0001; s = sel; end
      E_FULL:  d = 9'b1_0000_1000;
      E_LAF:   begin d = 9'b1_0001_0001; s = sel; end
      E_CPE:   d = 9'b1_0000_0100;
      E_DROP:  d = 9'b0_0000_0010;
      default: d = 9'b0;
    endcase
    return {d, s, wto};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
    din = 2'd0; fifo_empty = 3'b111; fifo_full = 3'b000; soft_rst = 3'b000;
    step(); step();
    check_eq("reset_a", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));
    check_eq("reset_b", 32'(obs_b), 32'(exp_word(E_DA, 3'b000, 1'b0)));
    rstn = 1'b1;

    // Packet to channel 2, FIFO empty, 4 payload cycles.
    din = 2'd2; pkt_valid = 1'b1;
    step(); check_eq("t1_lfd", 32'(obs_a), 32'(exp_word(E_LFD, 3'b100, 1'b0)));
    for (int i = 0; i < 4; i++) begin
      step(); check_eq("t1_ld", 32'(obs_a), 32'(exp_word(E_LD, 3'b100, 1'b0)));
      if (i == 3) pkt_valid = 1'b0;
    end
    step(); check_eq("t1_lp", 32'(obs_a), 32'(exp_word(E_LP, 3'b100, 1'b0)));
    step(); check_eq("t1_cpe", 32'(obs_a), 32'(exp_word(E_CPE, 3'b000, 1'b0)));
    step(); check_eq("t1_da", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));

    // Channel 1 not empty; drains after 5 wait cycles.
    din = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b101;
    for (int i = 0; i < 5; i++) begin
      step(); check_eq("t2_wait", 32'(obs_a), 32'(exp_word(E_WAIT, 3'b000, 1'b0)));
    end
    fifo_empty = 3'b111;
    step(); check_eq("t2_lfd", 32'(obs_a), 32'(exp_word(E_LFD, 3'b010, 1'b0)));
    check_eq("t2_lfd_b", 32'(obs_b), 32'(exp_word(E_LFD, 3'b010, 1'b0)));
    pkt_valid = 1'b0;
    step(); check_eq("t2_ld", 32'(obs_a), 32'(exp_word(E_LD, 3'b010, 1'b0)));
    step(); check_eq("t2_lp", 32'(obs_a), 32'(exp_word(E_LP, 3'b010, 1'b0)));
    step(); check_eq("t2_cpe", 32'(obs_a), 32'(exp_word(E_CPE, 3'b000, 1'b0)));
    step(); check_eq("t2_da", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));

    // Channel 0 never drains: 8-cycle budget drops, 32-cycle budget keeps waiting.
    din = 2'd0; pkt_valid = 1'b1; fifo_empty = 3'b110;
    for (int i = 0; i < 8; i++) begin
      step(); check_eq("t3_wait_b", 32'(obs_b), 32'(exp_word(E_WAIT, 3'b000, 1'b0)));
    end
    step(); check_eq("t3_drop_to", 32'(obs_b), 32'(exp_word(E_DROP, 3'b000, 1'b1)));
    step(); check_eq("t3_drop", 32'(obs_b), 32'(exp_word(E_DROP, 3'b000, 1'b0)));
    pkt_valid = 1'b0;
    step(); check_eq("t3_da_b", 32'(obs_b), 32'(exp_word(E_DA, 3'b000, 1'b0)));
    check_eq("t3_wait_a", 32'(obs_a), 32'(exp_word(E_WAIT, 3'b000, 1'b0)));
    rstn = 1'b0; fifo_empty = 3'b111;
    step(); rstn = 1'b1;
    check_eq("t3_rst_a", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));

    // Out-of-range address 3 is dropped.
    din = 2'd3; pkt_valid = 1'b1;
    step(); check_eq("t4_drop", 32'(obs_a), 32'(exp_word(E_DROP, 3'b000, 1'b0)));
    step(); check_eq("t4_drop2", 32'(obs_a), 32'(exp_word(E_DROP, 3'b000, 1'b0)));
    pkt_valid = 1'b0;
    step(); check_eq("t4_da", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));

    // Full stall on channel 0, resume, parity, full at parity check, parity_done exit.
    din = 2'd0; pkt_valid = 1'b1;
    step(); check_eq("t5_lfd", 32'(obs_a), 32'(exp_word(E_LFD, 3'b001, 1'b0)));
    step(); check_eq("t5_ld", 32'(obs_a), 32'(exp_word(E_LD, 3'b001, 1'b0)));
    fifo_full = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step(); check_eq("t5_full", 32'(obs_a), 32'(exp_word(E_FULL, 3'b000, 1'b0)));
    end
    fifo_full = 3'b000;
    step(); check_eq("t5_laf", 32'(obs_a), 32'(exp_word(E_LAF, 3'b001, 1'b0)));
    low_pkt_valid = 1'b1;
    step(); check_eq("t5_lp", 32'(obs_a), 32'(exp_word(E_LP, 3'b001, 1'b0)));
    low_pkt_valid = 1'b0; fifo_full = 3'b001;
    step(); check_eq("t5_cpe", 32'(obs_a), 32'(exp_word(E_CPE, 3'b000, 1'b0)));
    step(); check_eq("t5_full2", 32'(obs_a), 32'(exp_word(E_FULL, 3'b000, 1'b0)));
    fifo_full = 3'b000;
    step(); check_eq("t5_laf2", 32'(obs_a), 32'(exp_word(E_LAF, 3'b001, 1'b0)));
    parity_done = 1'b1; pkt_valid = 1'b0;
    step(); check_eq("t5_da", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));
    parity_done = 1'b0;

    // Soft resets: foreign channel ignored, own channel aborts, ignored in decode.
    din = 2'd0; pkt_valid = 1'b1;
    step(); step(); check_eq("t6_ld", 32'(obs_a), 32'(exp_word(E_LD, 3'b001, 1'b0)));
    soft_rst = 3'b010;
    step(); check_eq("t6_srst_other", 32'(obs_a), 32'(exp_word(E_LD, 3'b001, 1'b0)));
    soft_rst = 3'b001;
    step(); check_eq("t6_srst_own", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));
    step(); check_eq("t6_srst_in_da", 32'(obs_a), 32'(exp_word(E_LFD, 3'b001, 1'b0)));
    soft_rst = 3'b000;
    step(); check_eq("t6_ld2", 32'(obs_a), 32'(exp_word(E_LD, 3'b001, 1'b0)));
    rstn = 1'b0;
    step(); check_eq("t6_rst_mid", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));
    rstn = 1'b1; pkt_valid = 1'b0;
    step(); check_eq("t6_idle", 32'(obs_a), 32'(exp_word(E_DA, 3'b000, 1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised packet-router control FSM for a 1-to-N router. It decodes the header address, steers writes to one of NUM_CH output FIFOs, and sequences the standard flow: first data, payload, parity, FIFO-full stall, parity check. Over the 1x3 generation it adds a configurable channel count, one-hot write select, per-channel soft reset, drop of packets with out-of-range addresses, and an optional wait-for-empty timeout.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..2**ADDR_W)
ADDR_W, 2, width of header address field on din
WAIT_TIMEOUT, 32, max cycles in WAIT_TILL_EMPTY before packet is dropped; 0 = no timeout

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset rstn, synchronous, active-low
pkt_valid  in  1  header/payload byte valid from source
low_pkt_valid  in  1  packet-end indication from register block
parity_done  in  1  parity byte captured by register block
din  in  ADDR_W  header address bits (low bits of data bus)
fifo_empty  in  NUM_CH  per-FIFO empty
fifo_full  in  NUM_CH  per-FIFO full
soft_rst  in  NUM_CH  per-FIFO read-timeout soft reset
busy  out  1  stall to source
detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state  out  1 each  state decodes
we_reg  out  1  write enable to FIFO
wr_sel  out  NUM_CH  one-hot destination FIFO select
wait_timeout  out  1  one-cycle pulse: packet dropped on timeout

Behaviour:
- States: DECODE_ADDR, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PKT.
- Priority each edge: !rstn > soft_rst[addr_q] (any state except DECODE_ADDR) > next state. soft_rst of non-selected channels has no effect.
- Reset: state=DECODE_ADDR, addr_q=0, wait counter=0, wait_timeout=0. Outputs: detect_add=1, all others 0, busy=0, wr_sel=0.
- addr_q loads din only in DECODE_ADDR with pkt_valid=1; otherwise holds. F=fifo_full[addr_q], E=fifo_empty[addr_q].
- DECODE_ADDR: pkt_valid & din<NUM_CH & fifo_empty[din] -> LOAD_FIRST_DATA. pkt_valid & din<NUM_CH & !fifo_empty[din] -> WAIT_TILL_EMPTY. pkt_valid & din>=NUM_CH -> DROP_PKT. Otherwise stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- WAIT_TILL_EMPTY: counter cleared on entry, +1 per cycle in state. E -> LOAD_FIRST_DATA (empty wins over timeout in the same cycle). Else if WAIT_TIMEOUT!=0 and count==WAIT_TIMEOUT-1 -> DROP_PKT, wait_timeout=1 for the first DROP_PKT cycle only. Else stay.
- LOAD_DATA: F -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- FIFO_FULL_STATE: !F -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDR; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
- CHECK_PARITY_ERROR: F -> FIFO_FULL_STATE; else DECODE_ADDR.
- DROP_PKT: bytes are accepted and discarded. !pkt_valid -> DECODE_ADDR; else stay. The trailing parity byte arrives with pkt_valid=0 and is ignored.
- Moore outputs decoded from state: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg (CHECK_PARITY_ERROR), drop_state (DROP_PKT).
- we_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
- wr_sel = onehot(addr_q) in LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; 0 elsewhere. Never asserted in DROP_PKT.
- busy=0 in DECODE_ADDR, LOAD_DATA, DROP_PKT; 1 in all other states.
- State encoding is 4-bit. Unused codes -> DECODE_ADDR next cycle.

Test Plan:
- NUM_CH=3. Header din=2 with fifo_empty=3'b111, 4 payload bytes, then pkt_valid low -> sequence DECODE, LFD, LD x4, LP, CPE, DECODE. wr_sel=3'b100 from LFD through LP. busy low only in DECODE/LD.
- Header din=1 with fifo_empty[1]=0, empty rises after 5 cycles (WAIT_TIMEOUT=32) -> 5 cycles of WAIT with busy=1, then LFD. wait_timeout stays 0.
- Header din=0, fifo_empty[0] held 0, WAIT_TIMEOUT=8 -> exactly 8 WAIT cycles, then DROP_PKT with one-cycle wait_timeout. After pkt_valid falls -> DECODE. we_reg=0 and wr_sel=0 throughout.
- Header din=3 (NUM_CH=3) -> DROP_PKT next cycle, drop_state=1, busy=0, wr_sel=0. Returns to DECODE after pkt_valid drops.
- fifo_full[addr_q]=1 in LOAD_DATA for 3 cycles -> FULL x3, then LAF. low_pkt_valid=1 -> LP. parity_done=1 in LAF -> DECODE.
- soft_rst[1] pulse mid-LOAD_DATA to ch0 -> no effect. soft_rst[0] pulse -> DECODE next cycle. rstn=0 mid-packet -> DECODE with detect_add=1 and all other outputs 0.
